// File: rtl/pcie_transmisor_serial_pkg.sv
// Shared definitions for the pcie_transmisor_serial transmitter.
// Holds the width-select encodings, the symbol width, the running-disparity
// encoding, the K-code constants and small helpers for counting and lookup.
package pcie_transmisor_serial_pkg;

    localparam int SYM_W = 10;

    typedef enum logic [1:0] {
        SEL_8    = 2'b00,
        SEL_16   = 2'b01,
        SEL_32   = 2'b10,
        SEL_RSVD = 2'b11
    } sel_e;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [7:0] K28_5 = 8'hBC;

    localparam int NUM_VALID_K = 12;
    // K28.0..K28.7, then K23.7, K27.7, K29.7, K30.7
    localparam logic [7:0] VALID_K [NUM_VALID_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    // Population count of a symbol-sized vector (sub-blocks are zero-extended).
    function automatic logic [3:0] ones_cnt(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // True when the byte is one of the twelve legal control characters.
    function automatic logic is_valid_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_VALID_K; i++) begin
            if (b == VALID_K[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Index of the last byte of a word for a given width select.
    function automatic logic [1:0] last_byte_idx(input sel_e s);
        logic [1:0] idx;
        case (s)
            SEL_16:  idx = 2'd1;
            SEL_32:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/pcie_transmisor_serial_encoder_8b10b.sv
// Combinational 8b/10b encoder with running disparity.
// Ports: data_byte (HGF EDCBA), k_flag (request control encoding), rd_in
// (current running disparity); symbol ({abcdei, fghj}, a in the MSB),
// rd_out (disparity after this symbol), invalid (K requested on a byte that
// is not a legal control character; such bytes are encoded as data).
module pcie_transmisor_serial_encoder_8b10b
    import pcie_transmisor_serial_pkg::*;
(
    input  logic [7:0]       data_byte,
    input  logic             k_flag,
    input  logic             rd_in,
    output logic [SYM_W-1:0] symbol,
    output logic             rd_out,
    output logic             invalid
);

    logic [4:0] x_s;
    logic [2:0] y_s;
    logic       use_k_s;
    logic [5:0] code6_neg_s;
    logic [5:0] code6_s;
    logic       rd_mid_s;
    logic [3:0] code4_neg_s;
    logic [3:0] code4_s;
    logic       flip4_s;
    logic       alt7_s;

    // Table lookup of both sub-blocks and disparity bookkeeping.
    always_comb begin
        x_s         = data_byte[4:0];
        y_s         = data_byte[7:5];
        use_k_s     = k_flag & is_valid_k(data_byte);
        invalid     = k_flag & ~is_valid_k(data_byte);
        code6_neg_s = 6'b000000;
        code4_neg_s = 4'b0000;
        flip4_s     = 1'b0;
        alt7_s      = 1'b0;

        // 5b/6b, RD- column
        case (x_s)
            5'd0:  code6_neg_s = 6'b100111;
            5'd1:  code6_neg_s = 6'b011101;
            5'd2:  code6_neg_s = 6'b101101;
            5'd3:  code6_neg_s = 6'b110001;
            5'd4:  code6_neg_s = 6'b110101;
            5'd5:  code6_neg_s = 6'b101001;
            5'd6:  code6_neg_s = 6'b011001;
            5'd7:  code6_neg_s = 6'b111000;
            5'd8:  code6_neg_s = 6'b111001;
            5'd9:  code6_neg_s = 6'b100101;
            5'd10: code6_neg_s = 6'b010101;
            5'd11: code6_neg_s = 6'b110100;
            5'd12: code6_neg_s = 6'b001101;
            5'd13: code6_neg_s = 6'b101100;
            5'd14: code6_neg_s = 6'b011100;
            5'd15: code6_neg_s = 6'b010111;
            5'd16: code6_neg_s = 6'b011011;
            5'd17: code6_neg_s = 6'b100011;
            5'd18: code6_neg_s = 6'b010011;
            5'd19: code6_neg_s = 6'b110010;
            5'd20: code6_neg_s = 6'b001011;
            5'd21: code6_neg_s = 6'b101010;
            5'd22: code6_neg_s = 6'b011010;
            5'd23: code6_neg_s = 6'b111010;
            5'd24: code6_neg_s = 6'b110011;
            5'd25: code6_neg_s = 6'b100110;
            5'd26: code6_neg_s = 6'b010110;
            5'd27: code6_neg_s = 6'b110110;
            5'd28: code6_neg_s = use_k_s ? 6'b001111 : 6'b001110;
            5'd29: code6_neg_s = 6'b101110;
            5'd30: code6_neg_s = 6'b011110;
            default: code6_neg_s = 6'b101011;
        endcase

        // Unbalanced codes and D.07 take the complement when RD is positive.
        if ((rd_in == RD_POS) &&
            ((ones_cnt({4'b0000, code6_neg_s}) != 4'd3) || (x_s == 5'd7))) begin
            code6_s = ~code6_neg_s;
        end else begin
            code6_s = code6_neg_s;
        end
        rd_mid_s = rd_in ^ (ones_cnt({4'b0000, code6_neg_s}) != 4'd3);

        // 3b/4b, RD- column; control codes always alternate with RD.
        if (use_k_s) begin
            flip4_s = 1'b1;
            case (y_s)
                3'd0:    code4_neg_s = 4'b1011;
                3'd1:    code4_neg_s = 4'b0110;
                3'd2:    code4_neg_s = 4'b1010;
                3'd3:    code4_neg_s = 4'b1100;
                3'd4:    code4_neg_s = 4'b1101;
                3'd5:    code4_neg_s = 4'b0101;
                3'd6:    code4_neg_s = 4'b1001;
                default: code4_neg_s = 4'b0111;
            endcase
        end else begin
            // A7 avoids a run of five equal bits across the sub-block seam.
            if (rd_mid_s == RD_NEG) begin
                alt7_s = (x_s == 5'd17) || (x_s == 5'd18) || (x_s == 5'd20);
            end else begin
                alt7_s = (x_s == 5'd11) || (x_s == 5'd13) || (x_s == 5'd14);
            end
            case (y_s)
                3'd0:    code4_neg_s = 4'b1011;
                3'd1:    code4_neg_s = 4'b1001;
                3'd2:    code4_neg_s = 4'b0101;
                3'd3:    code4_neg_s = 4'b1100;
                3'd4:    code4_neg_s = 4'b1101;
                3'd5:    code4_neg_s = 4'b1010;
                3'd6:    code4_neg_s = 4'b0110;
                default: code4_neg_s = alt7_s ? 4'b0111 : 4'b1110;
            endcase
            flip4_s = (ones_cnt({6'b000000, code4_neg_s}) != 4'd2) || (y_s == 3'd3);
        end

        if ((rd_mid_s == RD_POS) && flip4_s) begin
            code4_s = ~code4_neg_s;
        end else begin
            code4_s = code4_neg_s;
        end
        rd_out = rd_mid_s ^ (ones_cnt({6'b000000, code4_neg_s}) != 4'd2);
        symbol = {code6_s, code4_s};
    end

endmodule

// File: rtl/pcie_transmisor_serial.sv
// Serial 8b/10b transmitter: captures an 8/16/32-bit word, encodes each byte
// (most significant first) with running disparity and shifts the symbols out
// one bit per enabled clock in order a,b,c,d,e,i,f,g,h,j.
// Ports: clk, rst (async, active-high), enb (freezes all state when low),
// K (control flag for the whole word), dataIn/dataIn16/dataIn32 (word per
// width), dataS (00=8b, 01=16b, 10=32b, 11=8b), serialOut (registered line).
// Build option TX_INVALID_OUT_EN adds invalidValue, high for the ten
// bit-times of any symbol whose byte was flagged K but is not a legal K code.
module pcie_transmisor_serial
    import pcie_transmisor_serial_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        K,
    input  logic [7:0]  dataIn,
    input  logic [15:0] dataIn16,
    input  logic [31:0] dataIn32,
    input  logic [1:0]  dataS,
`ifdef TX_INVALID_OUT_EN
    output logic        invalidValue,
`endif
    output logic        serialOut
);

    logic [3:0]       bit_cnt_r;
    logic [1:0]       byte_cnt_r;
    logic [1:0]       last_idx_r;
    logic [31:0]      word_r;
    logic             k_r;
    logic [SYM_W-1:0] shift_r;
    logic             rd_r;
    logic             serial_r;

    logic             load_s;
    logic             capture_s;
    logic [31:0]      aligned_s;
    logic [31:0]      cur_word_s;
    logic             cur_k_s;
    logic [7:0]       cur_byte_s;
    logic [SYM_W-1:0] sym_s;
    logic             rd_next_s;
    logic             invalid_s;

    // Byte selection; on a capture edge the encoder sees the incoming word directly.
    always_comb begin
        load_s    = (bit_cnt_r == 4'd0);
        capture_s = load_s && (byte_cnt_r == 2'd0);
        case (sel_e'(dataS))
            SEL_16:  aligned_s = {dataIn16, 16'h0000};
            SEL_32:  aligned_s = dataIn32;
            default: aligned_s = {dataIn, 24'h000000};
        endcase
        if (capture_s) begin
            cur_word_s = aligned_s;
            cur_k_s    = K;
        end else begin
            cur_word_s = word_r;
            cur_k_s    = k_r;
        end
        case (byte_cnt_r)
            2'd0:    cur_byte_s = cur_word_s[31:24];
            2'd1:    cur_byte_s = cur_word_s[23:16];
            2'd2:    cur_byte_s = cur_word_s[15:8];
            default: cur_byte_s = cur_word_s[7:0];
        endcase
    end

    pcie_transmisor_serial_encoder_8b10b encoder_8b10b (
        .data_byte (cur_byte_s),
        .k_flag    (cur_k_s),
        .rd_in     (rd_r),
        .symbol    (sym_s),
        .rd_out    (rd_next_s),
        .invalid   (invalid_s)
    );

    // Bit and byte counters that pace symbols and word captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r  <= 4'd0;
            byte_cnt_r <= 2'd0;
        end else if (enb) begin
            if (bit_cnt_r == 4'd9) begin
                bit_cnt_r  <= 4'd0;
                byte_cnt_r <= (byte_cnt_r == last_idx_r) ? 2'd0 : byte_cnt_r + 2'd1;
            end else begin
                bit_cnt_r  <= bit_cnt_r + 4'd1;
                byte_cnt_r <= byte_cnt_r;
            end
        end else begin
            bit_cnt_r  <= bit_cnt_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Word register: holds the captured word, K flag and byte count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r     <= 32'h00000000;
            k_r        <= 1'b0;
            last_idx_r <= 2'd0;
        end else if (enb && capture_s) begin
            word_r     <= aligned_s;
            k_r        <= K;
            last_idx_r <= last_byte_idx(sel_e'(dataS));
        end else begin
            word_r     <= word_r;
            k_r        <= k_r;
            last_idx_r <= last_idx_r;
        end
    end

    // Shift register, running disparity and line output. On a load edge the
    // line still takes bit j of the previous symbol, so the stream has no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r  <= {SYM_W{1'b0}};
            rd_r     <= RD_NEG;
            serial_r <= 1'b0;
        end else if (enb) begin
            serial_r <= shift_r[SYM_W-1];
            if (load_s) begin
                shift_r <= sym_s;
                rd_r    <= rd_next_s;
            end else begin
                shift_r <= {shift_r[SYM_W-2:0], 1'b0};
                rd_r    <= rd_r;
            end
        end else begin
            shift_r  <= shift_r;
            rd_r     <= rd_r;
            serial_r <= serial_r;
        end
    end

    assign serialOut = serial_r;

`ifdef TX_INVALID_OUT_EN
    logic inv_sym_r;
    logic invalid_r;

    // Invalid flag follows its symbol: latched at load, shown from bit a onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_sym_r <= 1'b0;
            invalid_r <= 1'b0;
        end else if (enb) begin
            inv_sym_r <= load_s ? invalid_s : inv_sym_r;
            invalid_r <= (bit_cnt_r == 4'd1) ? inv_sym_r : invalid_r;
        end else begin
            inv_sym_r <= inv_sym_r;
            invalid_r <= invalid_r;
        end
    end

    assign invalidValue = invalid_r;
`else
    logic unused_invalid_s;
    assign unused_invalid_s = invalid_s;
`endif

endmodule

// File: tb/tb_pcie_transmisor_serial.sv
module tb_pcie_transmisor_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        K;
    logic [7:0]  dataIn;
    logic [15:0] dataIn16;
    logic [31:0] dataIn32;
    logic [1:0]  dataS;
    logic        serialOut;
`ifdef TX_INVALID_OUT_EN
    logic        invalidValue;
`endif

    pcie_transmisor_serial dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .K         (K),
        .dataIn    (dataIn),
        .dataIn16  (dataIn16),
        .dataIn32  (dataIn32),
        .dataS     (dataS),
`ifdef TX_INVALID_OUT_EN
        .invalidValue (invalidValue),
`endif
        .serialOut (serialOut)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];
    logic [9:0] fix_sym[$];
    logic       fix_rd[$];
    logic rd_m = 1'b0;
    logic chk_on = 1'b0;
    logic skip_next = 1'b0;
    logic last_exp = 1'b0;
    logic r_at, e_at, bit_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference 5b/6b, RD- column.
    function automatic logic [5:0] t6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0: c = 6'b100111;  5'd1: c = 6'b011101;  5'd2: c = 6'b101101;  5'd3: c = 6'b110001;
            5'd4: c = 6'b110101;  5'd5: c = 6'b101001;  5'd6: c = 6'b011001;  5'd7: c = 6'b111000;
            5'd8: c = 6'b111001;  5'd9: c = 6'b100101;  5'd10: c = 6'b010101; 5'd11: c = 6'b110100;
            5'd12: c = 6'b001101; 5'd13: c = 6'b101100; 5'd14: c = 6'b011100; 5'd15: c = 6'b010111;
            5'd16: c = 6'b011011; 5'd17: c = 6'b100011; 5'd18: c = 6'b010011; 5'd19: c = 6'b110010;
            5'd20: c = 6'b001011; 5'd21: c = 6'b101010; 5'd22: c = 6'b011010; 5'd23: c = 6'b111010;
            5'd24: c = 6'b110011; 5'd25: c = 6'b100110; 5'd26: c = 6'b010110; 5'd27: c = 6'b110110;
            5'd28: c = 6'b001110; 5'd29: c = 6'b101110; 5'd30: c = 6'b011110; default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // Reference encoder: returns {rd_after, symbol}.
    function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic kf, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic kc, r, a7;
        logic [5:0] c6;
        logic [3:0] c4;
        x  = b[4:0];
        y  = b[7:5];
        kc = kf && ((x == 5'd28) || ((y == 3'd7) &&
             ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
        c6 = (kc && (x == 5'd28)) ? 6'b001111 : t6(x);
        if (rd && (($countones(c6) != 3) || (x == 5'd7))) c6 = ~c6;
        r  = rd ^ ($countones(c6) != 3);
        if (kc) begin
            case (y)
                3'd0: c4 = 4'b1011; 3'd1: c4 = 4'b0110; 3'd2: c4 = 4'b1010; 3'd3: c4 = 4'b1100;
                3'd4: c4 = 4'b1101; 3'd5: c4 = 4'b0101; 3'd6: c4 = 4'b1001; default: c4 = 4'b0111;
            endcase
            if (r) c4 = ~c4;
        end else begin
            a7 = r ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                   : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
            case (y)
                3'd0: c4 = r ? 4'b0100 : 4'b1011;
                3'd1: c4 = 4'b1001;
                3'd2: c4 = 4'b0101;
                3'd3: c4 = r ? 4'b0011 : 4'b1100;
                3'd4: c4 = r ? 4'b0010 : 4'b1101;
                3'd5: c4 = 4'b1010;
                3'd6: c4 = 4'b0110;
                default: c4 = a7 ? (r ? 4'b1000 : 4'b0111) : (r ? 4'b0001 : 4'b1110);
            endcase
        end
        return {rd ^ ($countones({c6, c4}) != 5), c6, c4};
    endfunction

    // Output checker: one expected bit per enabled edge, holds when disabled.
    always begin
        @(posedge clk);
        r_at = rst;
        e_at = enb;
        #1;
        if (chk_on && !r_at) begin
            if (!e_at) begin
                check_eq("hold", {31'd0, serialOut}, {31'd0, last_exp});
            end else if (skip_next) begin
                skip_next = 1'b0;
                last_exp  = 1'b0;
                check_eq("capture_edge", {31'd0, serialOut}, 32'd0);
            end else if (exp_q.size() == 0) begin
                check_eq("queue_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                bit_e    = exp_q.pop_front();
                last_exp = bit_e;
                check_eq("serial_bit", {31'd0, serialOut}, {31'd0, bit_e});
            end
        end
    end

    task automatic scramble();
        dataIn   = 8'($urandom);
        dataIn16 = 16'($urandom);
        dataIn32 = $urandom;
        dataS    = 2'($urandom_range(0, 3));
        K        = 1'($urandom_range(0, 1));
    endtask

    // Drive one word, queue its expected bits, optionally drop enb or abort with reset.
    task automatic run_word(input logic [1:0] sel, input logic kf, input logic [31:0] w,
                            input int drop_at, input int abort_at);
        int n;
        logic [31:0] al;
        logic [9:0]  sym;
        logic [10:0] res;
        @(negedge clk);
        dataS = sel; K = kf; dataIn = w[7:0]; dataIn16 = w[15:0]; dataIn32 = w; enb = 1'b1;
        n  = (sel == 2'b01) ? 2 : ((sel == 2'b10) ? 4 : 1);
        al = (n == 1) ? {w[7:0], 24'h0} : ((n == 2) ? {w[15:0], 16'h0} : w);
        for (int b = 0; b < n; b++) begin
            if (fix_sym.size() > 0) begin
                sym  = fix_sym.pop_front();
                rd_m = fix_rd.pop_front();
            end else begin
                res  = ref_enc(al[31-8*b -: 8], kf, rd_m);
                sym  = res[9:0];
                rd_m = res[10];
            end
            for (int i = 9; i >= 0; i--) exp_q.push_back(sym[i]);
        end
        for (int i = 0; i < 10 * n; i++) begin
            @(posedge clk);
            if (i == abort_at) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1 check_eq("reset_mid_word", {31'd0, serialOut}, 32'd0);
                enb = 1'b0;
                exp_q.delete();
                rd_m = 1'b0;
                last_exp = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                skip_next = 1'b1;
                return;
            end
            if (i < 10 * n - 1) begin
                @(negedge clk);
                scramble();
                if (i == drop_at) begin
                    enb = 1'b0;
                    repeat (5) @(negedge clk);
                    enb = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; K = 1'b0; dataS = 2'b00;
        dataIn = 8'h00; dataIn16 = 16'h0000; dataIn32 = 32'h0;
        repeat (3) @(posedge clk);
        #1 check_eq("reset_serial", {31'd0, serialOut}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        skip_next = 1'b1;

        // Known symbols: D0.0 from RD-, then K28.5 from RD- and RD+.
        fix_sym.push_back(10'b1001110100); fix_rd.push_back(1'b0);
        run_word(2'b00, 1'b0, 32'h00, -1, -1);
        fix_sym.push_back(10'b0011111010); fix_rd.push_back(1'b1);
        run_word(2'b00, 1'b1, 32'hBC, -1, -1);
        fix_sym.push_back(10'b1100000101); fix_rd.push_back(1'b0);
        run_word(2'b00, 1'b1, 32'hBC, -1, -1);

        run_word(2'b01, 1'b0, 32'h0000ABCD, -1, -1);
        run_word(2'b10, 1'b0, 32'h0123456F, -1, -1);
        run_word(2'b11, 1'b0, 32'h000000F1, -1, -1);
        run_word(2'b10, 1'b1, 32'hF73CFB55, -1, -1);
        run_word(2'b01, 1'b0, 32'h0000EBF1, -1, -1);
        run_word(2'b10, 1'b0, 32'hE7ED6B07, -1, -1);
        run_word(2'b01, 1'b0, 32'h00001234, 13, -1);
        for (int j = 0; j < 12; j++) begin
            run_word(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, -1, -1);
        end
        run_word(2'b10, 1'b0, 32'hDEADBEEF, -1, 15);
        run_word(2'b00, 1'b1, 32'hBC, -1, -1);
        run_word(2'b10, 1'b1, 32'hFCFD1CFE, 4, -1);

        @(posedge clk);
        #2;
        chk_on = 1'b0;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcie_transmisor_serial.md
Name: pcie_transmisor_serial

Overview:
- Transmit side of the PCIe-style interface.
- Takes an 8-, 16- or 32-bit parallel word, encodes each byte with 8b/10b using running disparity, and shifts the symbols out one bit per clock on a single serial line.
- Word period is 10 clocks for 8-bit mode, 20 for 16-bit and 40 for 32-bit. Upstream logic therefore updates its data at those rates.

Parameters:
- SYM_W, 10, width of one encoded symbol (bits per byte on the line).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- enb  input  1  enable; when low, all state freezes.
- K  input  1  control-character flag; applies to every byte of the captured word.
- dataIn  input  8  word for dataS=00.
- dataIn16  input  16  word for dataS=01.
- dataIn32  input  32  word for dataS=10.
- dataS  input  2  width select: 00=8b, 01=16b, 10=32b, 11=treated as 8b.
- serialOut  output  1  serial bit stream, registered.

Behaviour:
- Reset (async, rst=1): serialOut=0, running disparity=RD-, bit counter=0, byte counter=0, shift register=0.
- Capture:
  - Occurs on a rising edge with enb=1, bit counter=0 and byte counter=0.
  - Samples dataS, K and the selected data word into a word register.
  - Byte count N = 1/2/4 from dataS.
  - dataS and data changes between captures are ignored.
- Byte order: most significant byte first (32b: [31:24], [23:16], [15:8], [7:0]).
- Encode:
  - On each byte start (bit counter=0), the current byte is 8b/10b encoded combinationally with current RD.
  - The result is loaded into the 10-bit shift register; RD is updated from the symbol disparity.
  - Standard 5b/6b + 3b/4b tables, including A7 alternate and RD rules.
- K=1 handling:
  - If the byte is one of the 12 valid K codes (K28.0-7, K23.7, K27.7, K29.7, K30.7), it is encoded as control.
  - Otherwise the byte is encoded as data.
- Serialize:
  - Bit order a,b,c,d,e,i,f,g,h,j.
  - serialOut takes bit a on the edge after load, then one bit per enabled clock.
  - Latency: bit a of the first symbol appears 1 clock after capture.
- Counters:
  - Bit counter 0..9 wraps; at wrap the byte counter increments.
  - When byte counter reaches N-1 and the bit counter wraps, the next edge captures a new word.
  - Output is continuous with no idle gap.
- enb=0: counters, shift register, RD and serialOut hold their values; capture is deferred.
- rst asserted mid-symbol: immediate return to reset state; the partial symbol is discarded and RD returns to RD-.

Optional Feature:
- Macro TX_INVALID_OUT_EN.
- Defined: adds output port invalidValue (1 bit, reset 0), registered alongside serialOut. It is high for all 10 bit-times of any symbol where K=1 but the byte is not a valid K code.
- Undefined: port absent; invalid K bytes are silently encoded as data.

Decomposition:
- Shared package holds:
  - dataS encodings (SEL_8=2'b00, SEL_16=2'b01, SEL_32=2'b10).
  - SYM_W=10.
  - RD encoding (RD_NEG=0, RD_POS=1).
  - Constants K28_5=8'hBC and the valid-K byte list.
- One natural sub-module: encoder_8b10b. It is combinational: inputs byte, K and RD; outputs 10-bit symbol, new RD and invalid flag.

Test Plan:
- Reset, then enb=1, dataS=00, dataIn=8'h00, K=0 -> serialOut bits 1,0,0,1,1,1,0,1,0,0 (D0.0, RD- then RD- after); next word starts at clock 11.
- dataS=00, K=1, dataIn=8'hBC from RD- -> 0,0,1,1,1,1,1,0,1,0; RD becomes +; the next K28.5 sends 1,1,0,0,0,0,0,1,0,1.
- dataS=01, dataIn16=16'hABCD -> byte 8'hAB serialized first, then 8'hCD; new capture exactly 20 clocks later; symbols match the 8b/10b table with RD carried between the two bytes.
- dataS=10, dataIn32=32'h0123456F -> 40-bit stream 8'h01, 8'h23, 8'h45, 8'h6F in order; data changes mid-period have no effect.
- enb dropped for 5 clocks mid-symbol -> serialOut holds; after re-enable the remaining bits continue with no loss or duplication.
- rst pulsed mid-word -> serialOut=0 immediately; after release and enb=1, the first symbol is encoded from RD-.
